// File: rtl/pipe_wb_regfile.sv
// Write-back stage and 32x32 general register file with two combinational
// read ports, same-cycle write-to-read bypass and a retired-write counter.
module pipe_wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wwreg,
  input  logic             wm2reg,
  input  logic [31:0]      wmo,
  input  logic [31:0]      walu,
  input  logic [4:0]       wrn,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  output logic [31:0]      qa,
  output logic [31:0]      qb,
  output logic [31:0]      wdi,
  output logic [CNT_W-1:0] nwr
);

  logic [31:0]      regs [0:31];
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             commit;
  logic [4:0]       rn [0:1];
  logic [31:0]      q  [0:1];

  assign wdi    = wm2reg ? wmo : walu;
  assign commit = clrn && wwreg && (wrn != 5'd0);

  // Entry 0 stays at its reset value forever; reads of r0 are forced to zero below.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wrn] <= wdi;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (commit) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign nwr   = cnt_reg;
  assign rn[0] = rna;
  assign rn[1] = rnb;

  // Both read ports share the same zero / bypass / array priority.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        q[gi] = '0;
        if (!clrn || rn[gi] == 5'd0) begin
          q[gi] = '0;
        end else if (commit && rn[gi] == wrn) begin
          q[gi] = wdi;
        end else begin
          q[gi] = regs[rn[gi]];
        end
      end
    end
  endgenerate

  assign qa = q[0];
  assign qb = q[1];

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Directed bench for pipe_wb_regfile; counter width reduced to 4 to reach wrap quickly.
module tb_pipe_wb_regfile;

  logic        clk = 1'b0;
  logic        clrn;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] wdi;
  logic [3:0]  nwr;

  int errors = 0;
  int checks = 0;

  pipe_wb_regfile #(.CNT_W(4)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wmo    (wmo),
    .walu   (walu),
    .wrn    (wrn),
    .rna    (rna),
    .rnb    (rnb),
    .qa     (qa),
    .qb     (qb),
    .wdi    (wdi),
    .nwr    (nwr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    if (obs === exp) $display("check %s ok value=%h", tag, obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0; wwreg = 1'b0; wm2reg = 1'b0; wmo = '0; walu = '0;
    wrn = '0; rna = 5'd3; rnb = 5'd4;
    #2;
    check("rst_qa", qa, 32'h0);
    check("rst_qb", qb, 32'h0);
    check("rst_nwr", {28'h0, nwr}, 32'h0);
    tick();
    @(negedge clk);
    clrn = 1'b1;

    // ALU write to r3
    wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h1234_5678; wmo = 32'hAAAA_0000; wrn = 5'd3;
    #1;
    check("wdi_alu", wdi, 32'h1234_5678);
    tick();
    wwreg = 1'b0; rna = 5'd3;
    #1;
    check("rd_r3", qa, 32'h1234_5678);
    check("nwr_1", {28'h0, nwr}, 32'd1);

    // memory write to r4
    @(negedge clk);
    wwreg = 1'b1; wm2reg = 1'b1; wmo = 32'hDEAD_BEEF; wrn = 5'd4;
    #1;
    check("wdi_mem", wdi, 32'hDEAD_BEEF);
    tick();
    wwreg = 1'b0; rnb = 5'd4;
    #1;
    check("rd_r4", qb, 32'hDEAD_BEEF);
    check("nwr_2", {28'h0, nwr}, 32'd2);

    // bypass over r7
    @(negedge clk);
    wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h11; wrn = 5'd7;
    tick();
    wwreg = 1'b0; rna = 5'd7; rnb = 5'd7;
    #1;
    check("r7_array", qa, 32'h11);
    wwreg = 1'b1; walu = 32'h22;
    #1;
    check("byp_qa", qa, 32'h22);
    check("byp_qb", qb, 32'h22);
    tick();
    wwreg = 1'b0;
    #1;
    check("r7_after_qa", qa, 32'h22);
    check("r7_after_qb", qb, 32'h22);
    check("nwr_4", {28'h0, nwr}, 32'd4);

    // r0 protection
    @(negedge clk);
    wwreg = 1'b1; wrn = 5'd0; walu = 32'hFFFF_FFFF; rna = 5'd0; rnb = 5'd0;
    #1;
    check("r0_same_qa", qa, 32'h0);
    check("r0_same_qb", qb, 32'h0);
    check("r0_wdi", wdi, 32'hFFFF_FFFF);
    tick();
    wwreg = 1'b0;
    #1;
    check("r0_after", qa, 32'h0);
    check("r0_nwr", {28'h0, nwr}, 32'd4);

    // wwreg low: no write, no bypass
    @(negedge clk);
    wwreg = 1'b0; wrn = 5'd9; walu = 32'h55; rna = 5'd9;
    #1;
    check("nowr_wdi", wdi, 32'h55);
    check("nowr_nobyp", qa, 32'h0);
    tick();
    check("nowr_r9", qa, 32'h0);
    check("nowr_nwr", {28'h0, nwr}, 32'd4);

    // bypass only on matching register
    @(negedge clk);
    wwreg = 1'b1; wrn = 5'd3; walu = 32'h99; rna = 5'd4; rnb = 5'd3;
    #1;
    check("byp_other", qa, 32'hDEAD_BEEF);
    check("byp_match", qb, 32'h99);
    tick();
    wwreg = 1'b0; rna = 5'd3;
    #1;
    check("r3_new", qa, 32'h99);
    check("nwr_5", {28'h0, nwr}, 32'd5);

    // asynchronous reset mid-stream
    @(negedge clk);
    wwreg = 1'b1; wrn = 5'd5; walu = 32'h77; rna = 5'd5; rnb = 5'd3;
    #1;
    clrn = 1'b0;
    #1;
    check("arst_qa", qa, 32'h0);
    check("arst_qb", qb, 32'h0);
    check("arst_nwr", {28'h0, nwr}, 32'h0);
    check("arst_wdi", wdi, 32'h77);
    tick();
    check("arst_hold_nwr", {28'h0, nwr}, 32'h0);
    @(negedge clk);
    clrn = 1'b1; wwreg = 1'b0;
    #1;
    check("post_r5", qa, 32'h0);
    check("post_r3", qb, 32'h0);
    rna = 5'd4;
    #1;
    check("post_r4", qa, 32'h0);

    // 17 commits on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'(i + 1); walu = 32'h100 + 32'(i);
      tick();
      if (i == 14) check("cnt_15", {28'h0, nwr}, 32'd15);
      if (i == 15) check("cnt_wrap0", {28'h0, nwr}, 32'd0);
    end
    @(negedge clk);
    wwreg = 1'b0; rna = 5'd2; rnb = 5'd17;
    #1;
    check("cnt_wrap1", {28'h0, nwr}, 32'd1);
    check("loop_r2", qa, 32'h101);
    check("loop_r17", qb, 32'h110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
